// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared ALU.
// One operation in flight at a time: IDLE (grant) -> EXEC (capture) -> RESP (handshake).
// Build option: define ALU_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority (requester 0 always wins).
module alu_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OPS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] srcA,
  output logic [WIDTH-1:0] srcB,
  output logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  // Codes at or above NUM_OPS are forwarded untouched; the 3-bit field bounds the range.
  if (NUM_OPS < 1 || NUM_OPS > 8) begin : g_num_ops_range
    $error("alu_arbiter: NUM_OPS must lie in 1..8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             grant;
  logic             grant_id;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

`ifdef ALU_ARB_RR_EN
  logic prio_q;

  // Arbitration: on contention the preferred requester wins; otherwise whoever is valid.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = prio_q;
    end else begin
      grant_id = req1_valid;
    end
  end

  // Preference pointer moves to the requester that lost (or was idle) at each grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (grant) begin
      prio_q <= ~grant_id;
    end
  end
`else
  // Arbitration: requester 0 wins whenever it is valid.
  always_comb begin
    grant_id = 1'b0;
    grant_id = ~req0_valid;
  end
`endif

  // Next-state and handshake decode; ready only in IDLE and never while in reset.
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          grant      = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and captured ALU response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        op_q <= grant_id ? req1_op : req0_op;
        a_q  <= grant_id ? req1_a  : req0_a;
        b_q  <= grant_id ? req1_b  : req0_b;
        id_q <= grant_id;
      end
      if (state_q == EXEC) begin
        result_q <= ALUResult;
        zero_q   <= zero;
      end
    end
  end

  assign srcA       = a_q;
  assign srcB       = b_q;
  assign ALUControl = op_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule
